// File: rtl/serial_pattern_feeder.sv
// Parallel-to-serial feeder for the serial sequence detector: WIDTH-bit words in, MSB-first bits out.
// Define SERIAL_PARITY_EN to append an even-parity bit after each word's data bits.
module serial_pattern_feeder #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

`ifdef SERIAL_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [NBITS-1:0]   r_sreg, w_sreg_nxt, w_frame;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_x_valid, r_word_done, r_busy;
  logic               w_last, w_load;

  // Parity rides along as the frame LSB, so it simply shifts out after the data.
`ifdef SERIAL_PARITY_EN
  assign w_frame = {din, ^din};
`else
  assign w_frame = din;
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last && !w_load) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_last    = (r_state == S_SHIFT) && (r_cnt == '0);
    din_ready = reset && ((r_state == S_IDLE) || w_last);
    w_load    = din_valid && din_ready;
  end

  // Shifting out the last bit leaves the register all-zero, which keeps x low while idle.
  always_comb begin
    w_sreg_nxt = r_sreg;
    w_cnt_nxt  = r_cnt;
    if (w_load) begin
      w_sreg_nxt = w_frame;
      w_cnt_nxt  = CNT_W'(NBITS - 1);
    end else if (r_state == S_SHIFT) begin
      w_sreg_nxt = {r_sreg[NBITS-2:0], 1'b0};
      if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_x_valid   <= 1'b0;
      r_word_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sreg      <= w_sreg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_x_valid   <= (w_state_nxt == S_SHIFT);
      r_busy      <= (w_state_nxt == S_SHIFT);
      r_word_done <= (w_state_nxt == S_SHIFT) && (w_cnt_nxt == '0);
    end
  end

  assign x         = r_sreg[NBITS-1];
  assign x_valid   = r_x_valid;
  assign word_done = r_word_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Randomized bench for serial_pattern_feeder against a bit-queue reference model.
// Honours SERIAL_PARITY_EN the same way the design does.
module tb_serial_pattern_feeder;
  localparam int W = 8;
`ifdef SERIAL_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, x, x_valid, word_done, busy;

  int n_chk = 0, n_err = 0;

  // Model: queue of bits still to appear on x; element 0 is the bit on x this cycle.
  bit qx[$];
  bit qd[$];

  // Observation helpers for the directed cases.
  logic [31:0] obs;
  logic [4:0]  win;
  int          nbits, hits, nvalid;

  serial_pattern_feeder #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x(x), .x_valid(x_valid),
    .word_done(word_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NB-1:0] frame(input logic [W-1:0] d);
`ifdef SERIAL_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  // Called just after a falling edge: check this cycle, drive next edge, advance the model.
  task automatic cyc(input logic r, input logic v, input logic [W-1:0] d, output bit acc);
    bit ev;
    logic [NB-1:0] f;
    ev = (qx.size() != 0);
    chk("x",         x,         ev ? qx[0] : 1'b0);
    chk("x_valid",   x_valid,   ev);
    chk("busy",      busy,      ev);
    chk("word_done", word_done, ev ? qd[0] : 1'b0);
    chk("din_ready", din_ready, rst && (qx.size() <= 1));
    if (x_valid) begin
      obs = {obs[30:0], x};
      win = {win[3:0], x};
      nbits++;
      nvalid++;
      if (nbits >= 5 && win == 5'b10101) hits++;
    end
    rst = r; din_valid = v; din = d;
    acc = r && v && (qx.size() <= 1);
    if (!r) begin
      qx.delete(); qd.delete();
    end else begin
      if (qx.size() != 0) begin
        void'(qx.pop_front()); void'(qd.pop_front());
      end
      if (acc) begin
        f = frame(d);
        for (int i = NB - 1; i >= 0; i--) begin
          qx.push_back(f[i]);
          qd.push_back(i == 0);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, a);
  endtask

  // Hold a word valid until it is taken; the source changes din only after acceptance.
  task automatic send(input logic [W-1:0] d);
    bit a = 0;
    for (int i = 0; i < 64 && !a; i++) cyc(1'b1, 1'b1, d, a);
    if (!a) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit a;
    obs = '0; win = '0; nbits = 0; hits = 0; nvalid = 0;
    @(posedge clk);
    @(negedge clk);
    cyc(1'b0, 1'b0, '0, a);
    cyc(1'b0, 1'b0, '0, a);

    // Single word
    obs = '0;
    send(8'hA5);
    idle(NB + 2);
    chk("a5_word", obs[NB-1:0], frame(8'hA5));

    // Back-to-back
    obs = '0;
    send(8'hA8);
    send(8'h15);
    idle(2 * NB + 2);
    chk("b2b_word", obs[2*NB-1:0], {frame(8'hA8), frame(8'h15)});

    // Stall behind a word in flight
    obs = '0;
    send(8'h11);
    idle(2);
    send(8'h3C);
    idle(NB + 2);
    chk("stall_word", obs[NB-1:0], frame(8'h3C));

    // Reset while bit 4 of 8'hFF is on x
    send(8'hFF);
    idle(3);
    cyc(1'b0, 1'b0, '0, a);
    cyc(1'b0, 1'b0, '0, a);
    nvalid = 0;
    idle(4);
    chk("no_stale", nvalid, 0);

    // Detector chain: 10101 appears ending at bits 5 and 7
    win = '0; nbits = 0; hits = 0; nvalid = 0;
    send(8'hAA);
    idle(NB + 2);
    chk("det_hits", hits, 2);
    chk("det_valid", nvalid, NB);

    // Parity cases (plain shift without the parity feature)
    obs = '0;
    send(8'h07);
    idle(NB + 1);
    chk("w07", obs[NB-1:0], frame(8'h07));
    obs = '0;
    send(8'h03);
    idle(NB + 1);
    chk("w03", obs[NB-1:0], frame(8'h03));

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic r, v;
      r = ($urandom_range(99) != 0);
      v = ($urandom_range(9) < 7);
      cyc(r, v, W'($urandom), a);
    end
    idle(NB + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_pattern_feeder.md
Name: serial_pattern_feeder

Overview:
- Upstream stage of the serial sequence detector: a parallel-to-serial converter.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock.
- Drives the detector's serial input x, with a qualifying strobe and per-word status.
- Supports gap-free back-to-back words so bit patterns can span word boundaries.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter; derived from WIDTH, not overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset; sampled on rising clk; 0 = reset asserted.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept a word this cycle; combinational from state/counter only, never from din_valid.
- x  output  1  serial bit out, MSB first; registered.
- x_valid  output  1  x carries a real bit this cycle; registered.
- word_done  output  1  one-cycle pulse coincident with the final bit of a word; registered.
- busy  output  1  a word is in flight (state SHIFT); registered.

Behaviour:
- Reset: reset==0 at a rising edge forces the following, regardless of din_valid:
  - state=IDLE, shift reg=0, counter=0
  - x=0, x_valid=0, word_done=0, busy=0
- Reset mid-word abandons the word; no further bits are emitted for it.
- din_ready is 0 while reset==0.
- States:
  - IDLE: din_ready=1. On din_valid&&din_ready: load din into the shift reg, counter=WIDTH-1, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: x=shift_reg[MSB], x_valid=1. Each cycle, shift left by 1 and decrement the counter.
  - Last-bit cycle (counter==0 in SHIFT): din_ready=1 and word_done=1.
    - If din_valid, load the next word and stay in SHIFT; its MSB appears the very next cycle with no gap.
    - Otherwise go to IDLE.
- Latency: a word accepted at edge N puts its MSB on x in the cycle after edge N. The word occupies exactly WIDTH consecutive x_valid cycles.
- Handshake:
  - A transfer occurs only at an edge where din_valid && din_ready.
  - din_valid while din_ready=0 is ignored, and the word is not consumed; the source must hold it.
  - din is sampled only at the transfer edge.
- Idle output: when x_valid=0, x=0.
- Boundaries:
  - Continuous din_valid produces an unbroken bit stream with x_valid held high.
  - word_done pulses once per word, even back-to-back.
  - The counter never wraps below 0; the SHIFT exit is taken at 0.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra bit equal to the even parity (XOR) of the word is emitted, with x_valid=1.
  - Each word therefore occupies WIDTH+1 cycles.
  - word_done and din_ready move to the parity-bit cycle.
  - Back-to-back loading occurs on the parity cycle.
- Not defined: no parity bit; timing exactly as in Behaviour.

Test Plan:
- Single word: reset low 2 cycles, then high; din=8'hA5 with din_valid for 1 cycle.
  -> x=1,0,1,0,0,1,0,1 on 8 consecutive x_valid cycles starting the next cycle.
  -> word_done high only on the 8th; busy high for 8 cycles; then x=0, x_valid=0.
- Back-to-back: 8'hA8 then 8'h15, din_valid held.
  -> 16 unbroken x_valid cycles: 10101000 00010101.
  -> din_ready high only in IDLE and in cycles 8 and 16; word_done on cycles 8 and 16.
- Stall: assert din_valid with 8'h3C during cycle 3 of a word in flight.
  -> not accepted until that word's last-bit cycle.
  -> 00111100 follows immediately with no gap.
- Reset mid-word: reset=0 while the 4th bit of 8'hFF is on x.
  -> next cycle x=0, x_valid=0, busy=0, word_done=0, din_ready=0.
  -> after release, din_ready=1 and no stale bits are emitted.
- Detector chain: feed 8'b10101010 into the downstream detector.
  -> detector z pulses high on the 5th bit (and the 7th, via overlap).
  -> x_valid is continuous throughout.
- SERIAL_PARITY_EN: din=8'h07.
  -> x=00000111 then parity bit 1.
  -> word_done on the 9th cycle; 8'h03 gives parity bit 0.
